// File: rtl/mic3_pkg.sv
// Shared types and helpers for the Pmod MIC3 sampling sequencer.
package mic3_pkg;

    localparam int AUDIO_W = 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_REQ  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mic3_fifo.sv
// First-word-fall-through FIFO: dout shows the head combinationally, push and
// pop may coincide at any occupancy, a push into a full FIFO without a pop is dropped.
module mic3_fifo
    import mic3_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [clog2(DEPTH):0]  count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written, so full does not block it.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    // Storage is not reset; masking with empty keeps dout at 0 after reset.
    assign dout  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/mic3_sampler.sv
// Fixed-rate sequencer for the Pmod MIC3 reader: periodic one-cycle read requests,
// timed wait for the new-data pulse, FWFT sample buffer and sticky error flags.
module mic3_sampler
    import mic3_pkg::*;
#(
    parameter int PERIOD_W   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [PERIOD_W-1:0]         period,
    output logic                        mic_read,
    input  logic                        mic_new_data,
    input  logic [AUDIO_W-1:0]          mic_audio,
    output logic [AUDIO_W-1:0]          sample_data,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    output logic [clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                        busy,
    output logic                        late,
    output logic                        timeout_err,
    output logic                        overflow,
    input  logic                        err_clr
);

    localparam int TMO_W = clog2(TIMEOUT) + 1;

    state_t              state_reg;
    state_t              state_next;
    logic [PERIOD_W-1:0] cnt_reg;
    logic [PERIOD_W-1:0] cnt_next;
    logic [PERIOD_W-1:0] reload;
    logic                pend_reg;
    logic                pend_next;
    logic [TMO_W-1:0]    tmo_reg;
    logic [TMO_W-1:0]    tmo_next;
    logic                mic_read_reg;
    logic                late_reg;
    logic                late_next;
    logic                timeout_reg;
    logic                timeout_next;
    logic                overflow_reg;
    logic                overflow_next;

    logic tick;
    logic busy_w;
    logic push_w;
    logic late_set;
    logic tmo_set;
    logic overflow_set;
    logic fifo_full;
    logic fifo_empty;

    assign busy_w = (state_reg == S_REQ) || (state_reg == S_WAIT);
    assign tick   = (state_reg != S_IDLE) && (cnt_reg == '0);
    // A zero period behaves like a period of one cycle.
    assign reload = (period == '0) ? '0 : (period - PERIOD_W'(1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        tmo_next   = tmo_reg;
        push_w     = 1'b0;
        tmo_set    = 1'b0;
        late_set   = tick && (busy_w || pend_reg);

        if (state_reg == S_IDLE) begin
            cnt_next  = '0;
            // A stale tick must not fire a request on the next enable.
            pend_next = 1'b0;
        end else begin
            cnt_next = tick ? reload : (cnt_reg - PERIOD_W'(1));
            if (state_reg == S_REQ) pend_next = 1'b0;
            if (tick) pend_next = 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (enable) state_next = S_ARM;
            end
            S_ARM: begin
                if (!enable)              state_next = S_IDLE;
                else if (tick || pend_reg) state_next = S_REQ;
            end
            S_REQ: begin
                tmo_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mic_new_data) begin
                    push_w     = 1'b1;
                    state_next = enable ? S_ARM : S_IDLE;
                end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                    tmo_set    = 1'b1;
                    state_next = enable ? S_ARM : S_IDLE;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign overflow_set = push_w && fifo_full && !(sample_ready && !fifo_empty);

    // Sticky flags: a set event wins over a simultaneous clear.
    assign late_next     = late_set     | (late_reg     & ~err_clr);
    assign timeout_next  = tmo_set      | (timeout_reg  & ~err_clr);
    assign overflow_next = overflow_set | (overflow_reg & ~err_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            pend_reg     <= 1'b0;
            tmo_reg      <= '0;
            mic_read_reg <= 1'b0;
            late_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pend_reg     <= pend_next;
            tmo_reg      <= tmo_next;
            // Registered so the pulse is high exactly while the state is REQ.
            mic_read_reg <= (state_next == S_REQ);
            late_reg     <= late_next;
            timeout_reg  <= timeout_next;
            overflow_reg <= overflow_next;
        end
    end

    mic3_fifo #(
        .WIDTH (AUDIO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_w),
        .pop   (sample_ready),
        .din   (mic_audio),
        .dout  (sample_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign sample_valid = !fifo_empty;
    assign mic_read     = mic_read_reg;
    assign busy         = busy_w;
    assign late         = late_reg;
    assign timeout_err  = timeout_reg;
    assign overflow     = overflow_reg;

endmodule
